// File: rtl/plot_pkg.sv
// -----------------------------------------------------------------------------
// plot_pkg
// Constants and types shared by the bitmap reader and the plotter controller.
//   BMP_WIDTH / BMP_HEIGHT : thresholded bitmap size in pixels
//   BMP_ADDR_W             : black/white frame BRAM address width
//   BMP_READ_LATENCY       : BRAM read latency, address register -> data valid
//   COORD_W                : width of the x/y pixel coordinates
//   reader_state_t         : bitmap reader FSM states
// -----------------------------------------------------------------------------
package plot_pkg;

    localparam int BMP_WIDTH        = 106;
    localparam int BMP_HEIGHT       = 80;
    localparam int BMP_ADDR_W       = 14;
    localparam int BMP_READ_LATENCY = 2;
    localparam int COORD_W          = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        PRESENT = 2'd2
    } reader_state_t;

endpackage

// File: rtl/serpentine_addr_gen.sv
// -----------------------------------------------------------------------------
// serpentine_addr_gen
// Walks the bitmap in serpentine order: even rows left-to-right, odd rows
// right-to-left. Holds the current position and the start address of the
// current row, and offers the address of the following pixel so the caller
// can register it on the same edge that advances the position.
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_load        : restart at (0,0), row base 0
//   i_step        : advance to the next pixel in serpentine order
//   o_x, o_y      : current column / row
//   o_next_addr   : BRAM address of the pixel after the current one
//   o_last        : current pixel is the final pixel of the frame
// -----------------------------------------------------------------------------
module serpentine_addr_gen
    import plot_pkg::*;
#(
    parameter int WIDTH  = BMP_WIDTH,
    parameter int HEIGHT = BMP_HEIGHT,
    parameter int ADDR_W = BMP_ADDR_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_step,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic [ADDR_W-1:0]  o_next_addr,
    output logic               o_last
);

    localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(HEIGHT - 1);
    // An even row count finishes on a right-to-left row, i.e. at column 0.
    localparam logic [COORD_W-1:0] X_LAST   = (HEIGHT % 2 == 0) ? '0 : X_MAX;
    localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(WIDTH);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [ADDR_W-1:0]  r_row_base;
    logic               r_reverse;     // 1 on odd rows (right-to-left)

    logic [COORD_W-1:0] w_next_x;
    logic [COORD_W-1:0] w_next_y;
    logic [ADDR_W-1:0]  w_next_row_base;
    logic               w_next_reverse;
    logic               w_row_end;

    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        w_next_x        = r_x;
        w_next_y        = r_y;
        w_next_row_base = r_row_base;
        w_next_reverse  = r_reverse;
        w_row_end       = r_reverse ? (r_x == '0) : (r_x == X_MAX);

        if (w_row_end) begin
            // Drop to the next row at the same column and turn around; the
            // row base grows by one row so no multiplier is needed.
            w_next_y        = r_y + 1'b1;
            w_next_row_base = r_row_base + ROW_STEP;
            w_next_reverse  = !r_reverse;
        end else if (r_reverse) begin
            w_next_x = r_x - 1'b1;
        end else begin
            w_next_x = r_x + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (i_rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_row_base <= '0;
            r_reverse  <= 1'b0;
        end else if (i_load) begin
            r_x        <= '0;
            r_y        <= '0;
            r_row_base <= '0;
            r_reverse  <= 1'b0;
        end else if (i_step) begin
            r_x        <= w_next_x;
            r_y        <= w_next_y;
            r_row_base <= w_next_row_base;
            r_reverse  <= w_next_reverse;
        end
    end

    assign o_x         = r_x;
    assign o_y         = r_y;
    assign o_next_addr = w_next_row_base + ADDR_W'(w_next_x);
    assign o_last      = (r_y == Y_MAX) && (r_x == X_LAST);

endmodule

// File: rtl/plot_bitmap_reader.sv
// -----------------------------------------------------------------------------
// plot_bitmap_reader
// Reads the thresholded bitmap out of the black/white frame BRAM in
// serpentine order and hands it to the plotter one pixel per handshake.
// busy_out is ANDed (inverted) into the bitmap write enable at the top level
// so the image stays frozen while it is being plotted.
//   clk_in, rst_in   : 65 MHz clock, asynchronous active-high reset
//   start_in         : start pulse, honoured only when idle
//   abort_in         : abandon the plot, return to idle without done_out
//   ready_in         : plotter accepts the presented pixel
//   ram_data_in      : BRAM read data, READ_LATENCY cycles after addr_out
//   addr_out         : registered BRAM read address
//   pixel_out        : presented pixel, 1 = ink
//   pixel_valid_out  : pixel_out / x_out / y_out are valid
//   x_out, y_out     : coordinates of the presented pixel
//   busy_out         : plot in progress
//   done_out         : one-cycle pulse after the final pixel is accepted
// -----------------------------------------------------------------------------
module plot_bitmap_reader
    import plot_pkg::*;
#(
    parameter int WIDTH        = BMP_WIDTH,
    parameter int HEIGHT       = BMP_HEIGHT,
    parameter int ADDR_W       = BMP_ADDR_W,
    parameter int READ_LATENCY = BMP_READ_LATENCY
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start_in,
    input  logic               abort_in,
    input  logic               ready_in,
    input  logic               ram_data_in,
    output logic [ADDR_W-1:0]  addr_out,
    output logic               pixel_out,
    output logic               pixel_valid_out,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic               busy_out,
    output logic               done_out
);

    localparam int              CNT_W       = $clog2(READ_LATENCY + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_CAPTURE = CNT_W'(READ_LATENCY);

    reader_state_t     r_state;
    reader_state_t     w_state_next;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_load;
    logic              w_step;
    logic              w_capture;
    logic              w_xfer;
    logic              w_finish;
    logic              w_abort;
    logic              w_last;
    logic [ADDR_W-1:0] w_next_addr;

    serpentine_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_clk       (clk_in),
        .i_rst       (rst_in),
        .i_load      (w_load),
        .i_step      (w_step),
        .o_x         (x_out),
        .o_y         (y_out),
        .o_next_addr (w_next_addr),
        .o_last      (w_last)
    );

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic; abort wins over a simultaneous transfer.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start_in) w_state_next = WAIT;
            end
            WAIT: begin
                if (abort_in)                  w_state_next = IDLE;
                else if (r_cnt == CNT_CAPTURE) w_state_next = PRESENT;
            end
            PRESENT: begin
                if (abort_in)                          w_state_next = IDLE;
                else if (pixel_valid_out && ready_in)  w_state_next = w_last ? IDLE : WAIT;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output decode: per-cycle strobes driving the output registers.
    always_comb begin
        w_abort   = (r_state != IDLE) && abort_in;
        w_load    = (r_state == IDLE) && start_in;
        w_capture = (r_state == WAIT) && !abort_in && (r_cnt == CNT_CAPTURE);
        w_xfer    = (r_state == PRESENT) && pixel_valid_out && ready_in && !abort_in;
        w_step    = w_xfer && !w_last;
        w_finish  = w_xfer && w_last;
    end

    // Output registers. Later statements take priority, so the clears on
    // transfer/abort override the sets above them.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            addr_out        <= '0;
            pixel_out       <= 1'b0;
            pixel_valid_out <= 1'b0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
            r_cnt           <= '0;
        end else begin
            done_out <= w_finish;

            // The wait counter measures BRAM latency from the address edge.
            if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;

            if (w_load) begin
                addr_out <= '0;
                busy_out <= 1'b1;
                r_cnt    <= '0;
            end

            if (w_step) begin
                addr_out <= w_next_addr;
                r_cnt    <= '0;
            end

            if (w_capture) begin
                pixel_out       <= ram_data_in;
                pixel_valid_out <= 1'b1;
            end

            if (w_xfer || w_abort)   pixel_valid_out <= 1'b0;
            if (w_finish || w_abort) busy_out        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_plot_bitmap_reader.sv
// -----------------------------------------------------------------------------
// tb_plot_bitmap_reader
// Directed bench for plot_bitmap_reader: a default-size instance fed by a
// two-stage BRAM model (data = addr[0] ^ addr[7]) and a 3x2 instance with
// ready tied high. Expected positions come from an independent serpentine
// model using addr = y*WIDTH + x.
// -----------------------------------------------------------------------------
module tb_plot_bitmap_reader;

    logic        clk;
    logic        rst;
    logic        start, abort, ready, ram_data;
    logic [13:0] addr;
    logic        pixel, valid, busy, done;
    logic [6:0]  x, y;

    logic        s_start, s_abort, s_ready, s_ram_data;
    logic [13:0] s_addr;
    logic        s_pixel, s_valid, s_busy, s_done;
    logic [6:0]  s_x, s_y;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // serpentine model state for the default-size instance
    int mx, my, npix, done_cnt;
    int last_addr, last_x, last_y;

    plot_bitmap_reader u_dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .start_in        (start),
        .abort_in        (abort),
        .ready_in        (ready),
        .ram_data_in     (ram_data),
        .addr_out        (addr),
        .pixel_out       (pixel),
        .pixel_valid_out (valid),
        .x_out           (x),
        .y_out           (y),
        .busy_out        (busy),
        .done_out        (done)
    );

    plot_bitmap_reader #(.WIDTH(3), .HEIGHT(2)) u_small (
        .clk_in          (clk),
        .rst_in          (rst),
        .start_in        (s_start),
        .abort_in        (s_abort),
        .ready_in        (s_ready),
        .ram_data_in     (s_ram_data),
        .addr_out        (s_addr),
        .pixel_out       (s_pixel),
        .pixel_valid_out (s_valid),
        .x_out           (s_x),
        .y_out           (s_y),
        .busy_out        (s_busy),
        .done_out        (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model, read latency 2
    logic ram_d1, ram_d2;
    always @(posedge clk) begin
        ram_d1 <= addr[0] ^ addr[7];
        ram_d2 <= ram_d1;
    end
    assign ram_data   = ram_d2;
    assign s_ram_data = s_addr[0];

    task automatic model_advance();
        if (my % 2 == 0) begin
            if (mx < 105) mx++; else my++;
        end else begin
            if (mx > 0) mx--; else my++;
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mx = 0; my = 0; npix = 0; done_cnt = 0;
    endtask

    // Runs until n transfers have happened in total, checking each accepted pixel.
    task automatic drive_pixels(input int n, input bit rnd);
        int guard;
        logic [13:0] ea;
        guard = 0;
        while (npix < n && guard < 80000) begin
            @(negedge clk);
            guard++;
            if (done) done_cnt++;
            ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (valid && ready) begin
                ea = 14'(my * 106 + mx);
                total++;
                if (addr !== ea || x !== 7'(mx) || y !== 7'(my) || pixel !== (ea[0] ^ ea[7])) begin
                    bad++;
                    if (bad < 20)
                        $display("FAIL pixel_%0d: got addr=%0d x=%0d y=%0d pix=%0b, want addr=%0d x=%0d y=%0d pix=%0b",
                                 npix, addr, x, y, pixel, ea, mx, my, ea[0] ^ ea[7]);
                end
                last_addr = int'(addr); last_x = int'(x); last_y = int'(y);
                npix++;
                model_advance();
            end
        end
        total++;
        if (npix < n) begin
            bad++;
            $display("FAIL drive_timeout: transfers=%0d want %0d", npix, n);
        end
        @(negedge clk);
        if (done) done_cnt++;
        ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (addr !== 14'd0 || x !== 7'd0 || y !== 7'd0) begin bad++; $display("FAIL reset_pos: addr=%0d x=%0d y=%0d want 0", addr, x, y); end
        total++; if (valid !== 1'b0 || pixel !== 1'b0) begin bad++; $display("FAIL reset_pixel: valid=%0b pix=%0b want 0", valid, pixel); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_flags: busy=%0b done=%0b want 0", busy, done); end
        total++; if (s_addr !== 14'd0 || s_valid !== 1'b0 || s_busy !== 1'b0) begin bad++; $display("FAIL reset_small: addr=%0d valid=%0b busy=%0b want 0", s_addr, s_valid, s_busy); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_start_latency_hold();
        while (cyc < 9) @(negedge clk);
        start = 1'b1;                    // sampled at edge 10
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b1 || addr !== 14'd0 || valid !== 1'b0) begin bad++; $display("FAIL start_edge: busy=%0b addr=%0d valid=%0b want 1 0 0", busy, addr, valid); end
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL latency_e11: valid=%0b want 0", valid); end
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL latency_e12: valid=%0b want 0", valid); end
        @(negedge clk);
        total++; if (valid !== 1'b1 || x !== 7'd0 || y !== 7'd0 || pixel !== 1'b0) begin bad++; $display("FAIL latency_e13: valid=%0b x=%0d y=%0d pix=%0b want 1 0 0 0", valid, x, y, pixel); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (valid !== 1'b1 || pixel !== 1'b0 || x !== 7'd0 || y !== 7'd0 || addr !== 14'd0) begin
                bad++;
                $display("FAIL hold_%0d: valid=%0b pix=%0b x=%0d y=%0d addr=%0d want 1 0 0 0 0", i, valid, pixel, x, y, addr);
            end
        end
        mx = 0; my = 0; npix = 0; done_cnt = 0;
    endtask

    task automatic test_full_frame();
        drive_pixels(8480, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        total++; if (npix !== 8480) begin bad++; $display("FAIL frame_count: got %0d want 8480", npix); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL frame_done: got %0d pulses want 1", done_cnt); end
        total++; if (last_addr !== 8374 || last_x !== 0 || last_y !== 79) begin bad++; $display("FAIL frame_last: got addr=%0d (%0d,%0d) want 8374 (0,79)", last_addr, last_x, last_y); end
        total++; if (busy !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL frame_idle: busy=%0b valid=%0b want 0 0", busy, valid); end
    endtask

    task automatic test_small_frame();
        int exp_a [6] = '{0, 1, 2, 5, 4, 3};
        int exp_x [6] = '{0, 1, 2, 2, 1, 0};
        int exp_y [6] = '{0, 0, 0, 1, 1, 1};
        int k, done_at, six_at, sdone;
        k = 0; done_at = -1; six_at = -1; sdone = 0;
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (s_done) begin
                sdone++;
                if (done_at < 0) done_at = c;
            end
            if (s_valid && k < 6) begin
                total++;
                if (s_addr !== 14'(exp_a[k]) || s_x !== 7'(exp_x[k]) || s_y !== 7'(exp_y[k])) begin
                    bad++;
                    $display("FAIL small_px%0d: got addr=%0d x=%0d y=%0d want %0d %0d %0d", k, s_addr, s_x, s_y, exp_a[k], exp_x[k], exp_y[k]);
                end
                k++;
                if (k == 6) six_at = c;
            end
        end
        total++; if (k !== 6) begin bad++; $display("FAIL small_count: got %0d want 6", k); end
        total++; if (done_at !== six_at + 1) begin bad++; $display("FAIL small_done_time: got %0d want %0d", done_at, six_at + 1); end
        total++; if (sdone !== 1 || s_busy !== 1'b0) begin bad++; $display("FAIL small_done: pulses=%0d busy=%0b want 1 0", sdone, s_busy); end
    endtask

    task automatic test_abort();
        start_frame();
        drive_pixels(500, 1'b1);
        abort = 1'b1;                    // DUT is in WAIT after the 500th transfer
        @(negedge clk);
        abort = 1'b0;
        if (done) done_cnt++;
        total++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_idle: valid=%0b busy=%0b done=%0b want 0", valid, busy, done); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        total++; if (done_cnt !== 0 || valid !== 1'b0) begin bad++; $display("FAIL abort_nodone: pulses=%0d valid=%0b want 0 0", done_cnt, valid); end
        start_frame();
        drive_pixels(3, 1'b0);           // restart checked from addr 0
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_cleanup: busy=%0b want 0", busy); end
    endtask

    task automatic test_misc();
        int guard;
        start_frame();
        drive_pixels(1, 1'b0);
        ready = 1'b1;                    // ready pulse while in WAIT
        @(negedge clk);
        ready = 1'b0;
        guard = 0;
        while (!valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        total++; if (valid !== 1'b1 || x !== 7'd1 || y !== 7'd0 || addr !== 14'd1) begin bad++; $display("FAIL wait_ready: valid=%0b x=%0d y=%0d addr=%0d want 1 1 0 1", valid, x, y, addr); end
        start = 1'b1;                    // start in PRESENT
        @(negedge clk);
        start = 1'b0;
        total++; if (valid !== 1'b1 || x !== 7'd1 || addr !== 14'd1 || busy !== 1'b1) begin bad++; $display("FAIL present_start: valid=%0b x=%0d addr=%0d busy=%0b want 1 1 1 1", valid, x, addr, busy); end
        ready = 1'b1;                    // transfer and abort together
        abort = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        abort = 1'b0;
        total++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_xfer_flags: valid=%0b busy=%0b done=%0b want 0", valid, busy, done); end
        total++; if (addr !== 14'd1 || x !== 7'd1) begin bad++; $display("FAIL abort_xfer_pos: addr=%0d x=%0d want 1 1", addr, x); end
        @(negedge clk);
        total++; if (done !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL abort_xfer_after: done=%0b valid=%0b want 0 0", done, valid); end
    endtask

    task automatic test_reset_mid_wait();
        start_frame();
        drive_pixels(5, 1'b0);           // now in WAIT with addr 5
        #2 rst = 1'b1;
        #1;
        total++; if (addr !== 14'd0 || x !== 7'd0 || y !== 7'd0) begin bad++; $display("FAIL rst_mid_pos: addr=%0d x=%0d y=%0d want 0", addr, x, y); end
        total++; if (busy !== 1'b0 || valid !== 1'b0 || pixel !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_mid_flags: busy=%0b valid=%0b pix=%0b done=%0b want 0", busy, valid, pixel, done); end
        @(negedge clk);
        rst = 1'b0;
        start_frame();
        drive_pixels(10, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++; if (done_cnt !== 0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_restart: pulses=%0d busy=%0b want 0 0", done_cnt, busy); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0; abort = 1'b0; ready = 1'b0;
        s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b1;
        mx = 0; my = 0; npix = 0; done_cnt = 0;
        last_addr = 0; last_x = 0; last_y = 0;

        test_reset();
        test_start_latency_hold();
        test_full_frame();
        test_small_frame();
        test_abort();
        test_misc();
        test_reset_mid_wait();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plot_bitmap_reader.md
# plot_bitmap_reader

Reads the 106×80 1-bit thresholded bitmap out of the black/white frame BRAM and feeds it to the plotter controller, one pixel per request. Traversal is serpentine: even rows left-to-right, odd rows right-to-left, which minimises pen travel. While a plot is in progress, the block asserts a lock so the write side of the bitmap stays frozen. It sits between the `black_white` BRAM read port and `plotter_control`, all on the 65 MHz domain.

## Interface
Parameters:
- `WIDTH`, 106, bitmap columns
- `HEIGHT`, 80, bitmap rows
- `ADDR_W`, 14, BRAM address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT
- `READ_LATENCY`, 2, BRAM read latency in cycles (address registered → data valid)

Ports:
- `clk_in` input 1: 65 MHz system clock
- `rst_in` input 1: reset, asynchronous, active-high
- `start_in` input 1: single-cycle start pulse; sampled only in IDLE
- `abort_in` input 1: abandon the current plot
- `ready_in` input 1: plotter accepts the current pixel (`ready_next_pixel`)
- `ram_data_in` input 1: BRAM read data
- `addr_out` output ADDR_W: BRAM read address, registered
- `pixel_out` output 1: current pixel, 1 = ink
- `pixel_valid_out` output 1: `pixel_out`, `x_out` and `y_out` are valid
- `x_out` output 7: column of the current pixel
- `y_out` output 7: row of the current pixel
- `busy_out` output 1: plot in progress; top level ANDs `!busy_out` into the bitmap write enable
- `done_out` output 1: one-cycle pulse after the last pixel is transferred

## Operation
- States: IDLE, WAIT, PRESENT.
- IDLE:
  - `start_in` → load x=0, y=0, row_base=0.
  - `addr_out` ← 0, `busy_out` ← 1, wait counter ← 0, go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - In the cycle the counter equals READ_LATENCY, register `ram_data_in` into `pixel_out`, set `pixel_valid_out`, go to PRESENT.
- PRESENT:
  - Outputs are held stable until `pixel_valid_out && ready_in` (transfer).
  - On a transfer of a non-last pixel:
    - advance the position, register the new `addr_out`, clear `pixel_valid_out`, go to WAIT.
  - On a transfer of the last pixel:
    - clear `pixel_valid_out` and `busy_out`, pulse `done_out`, go to IDLE.
- Advance rule:
  - Even row: x+1 if x<WIDTH-1; otherwise y+1 with x unchanged.
  - Odd row: x-1 if x>0; otherwise y+1 with x unchanged.
- Address rule:
  - `addr_out` = row_base + x.
  - row_base is incremented by WIDTH on each row change. No multiplier.
- Last pixel:
  - Position (0, HEIGHT-1) if HEIGHT is even.
  - Position (WIDTH-1, HEIGHT-1) if HEIGHT is odd.
- `abort_in` in WAIT or PRESENT: next cycle in IDLE, with `pixel_valid_out`=0, `busy_out`=0 and no `done_out`. `abort_in` has priority over a simultaneous transfer.
- `start_in` outside IDLE is ignored. `ready_in` without `pixel_valid_out` is ignored.
- Reset values: every output is 0 and the state is IDLE. Reset takes effect immediately, independent of the clock, including mid-frame.

## Timing
- `start_in` sampled at edge N → `addr_out` valid after edge N → `pixel_valid_out` high after edge N+READ_LATENCY+1 (N+3 at default).
- Transfer at edge M → next `pixel_valid_out` high after edge M+READ_LATENCY+1.
- `pixel_valid_out` drops after edge M.
- Maximum throughput is one pixel per READ_LATENCY+2 cycles. The plotter is far slower, so this is not limiting.
- `done_out` is high for exactly the cycle following the final transfer edge. `busy_out` falls on the same edge.
- `addr_out` changes only on start or transfer edges; it is stable through WAIT and PRESENT.

## Structure
- Shared package `plot_pkg`:
  - `BMP_WIDTH`=106, `BMP_HEIGHT`=80, `BMP_ADDR_W`=14.
  - `reader_state_t` enum {IDLE, WAIT, PRESENT}.
- The `plotter_control` instantiation imports the same constants.
- One sub-module is natural: `serpentine_addr_gen` (x, y, row_base, direction, last flag; inputs `load`, `step`).
- The FSM and output registers stay in the top of this block.

## Test plan
- WIDTH=3, HEIGHT=2, `ready_in` tied high, start → addresses 0,1,2,5,4,3; x 0,1,2,2,1,0; y 0,0,0,1,1,1; `done_out` one cycle after the 6th transfer.
- Default size, start at edge 10 → `pixel_valid_out` high after edge 13. Hold `ready_in` low 20 cycles → `pixel_out`, `x_out`, `y_out` and `addr_out` stable throughout.
- Default size, BRAM model with data = addr[0]^addr[7], random `ready_in` → 8480 transfers, all data matching, final addr 8374 at (0,79), exactly one `done_out`.
- `abort_in` after the 500th transfer → IDLE next cycle, `busy_out`=0, no `done_out`. A new start begins again at addr 0.
- `rst_in` asserted between edges during WAIT → all outputs 0 immediately. After release, a start produces a clean frame from addr 0.
- `start_in` during PRESENT → no restart. `ready_in` pulses in WAIT → no position advance. Simultaneous `abort_in` + transfer → aborted, no advance.
